// File: rtl/j11pins.sv
// j11pins: pin-level front end for the DCJ11 CPU.
// Synchronises ALE_n/SCTL_n, latches the multiplexed DAL address and AIO
// code, and turns each J11 bus cycle into one single-cycle busreq
// transaction (two for read-modify-write). CONT_n holds the CPU until
// busack returns; read data is driven back onto DAL.
//
// Optional feature: define J11PINS_TIMEOUT_EN to add a busack wait limit of
// TIMEOUT_CYCLES. On expiry bustimeout pulses, reads return 16'o177777 and
// the cycle completes as if acked. Without the macro bustimeout is tied 0.
//
// Bus handshake: busreq is a one-cycle request pulse; busaddr, buswr, busgp,
// busbyte (and buswdata for writes) are held stable from busreq until the
// single-cycle busack, which completes the transaction. busack outside the
// two wait states is ignored.

module j11pins #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] dal_in,
    output logic [15:0] dal_out,
    output logic        dal_oe,
    input  logic [3:0]  aio,
    input  logic        ale_n,
    input  logic        sctl_n,
    output logic        cont_n,
    output logic        busreq,
    output logic        buswr,
    output logic        busgp,
    output logic        busbyte,
    output logic [21:0] busaddr,
    output logic [15:0] buswdata,
    input  logic        busack,
    input  logic [15:0] busrdata,
    output logic        bustimeout
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_RREQ, S_RWAIT, S_RDRIVE,
        S_RMWW, S_WREQ, S_WWAIT, S_WDONE
    } state_t;

    // Current state; kept as a named signal so checkers can bind to it.
    state_t state;

    logic [SYNC_STAGES-1:0] ale_sync, sctl_sync;
    logic ale_d, sctl_d;
    logic ale_fall, ale_rise, sctl_fall, sctl_rise;

    logic dec_valid, dec_rd, dec_rmw, dec_gp, dec_byte;
    logic cyc_rd, cyc_rmw;
    logic wait_expired;

    // Strobe synchronisers; reset to the inactive (high) level so no edge is seen at reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ale_sync  <= '1;
            sctl_sync <= '1;
            ale_d     <= 1'b1;
            sctl_d    <= 1'b1;
        end else begin
            ale_sync  <= {ale_sync[SYNC_STAGES-2:0], ale_n};
            sctl_sync <= {sctl_sync[SYNC_STAGES-2:0], sctl_n};
            ale_d     <= ale_sync[SYNC_STAGES-1];
            sctl_d    <= sctl_sync[SYNC_STAGES-1];
        end
    end

    assign ale_fall  = ale_d & ~ale_sync[SYNC_STAGES-1];
    assign ale_rise  = ~ale_d & ale_sync[SYNC_STAGES-1];
    assign sctl_fall = sctl_d & ~sctl_sync[SYNC_STAGES-1];
    assign sctl_rise = ~sctl_d & sctl_sync[SYNC_STAGES-1];

    // AIO cycle-code decode; unlisted codes behave as idle.
    always_comb begin
        dec_valid = 1'b0;
        dec_rd    = 1'b0;
        dec_rmw   = 1'b0;
        dec_gp    = 1'b0;
        dec_byte  = 1'b0;
        case (aio)
            4'b1000, 4'b1001: begin dec_valid = 1'b1; dec_rd = 1'b1; end
            4'b1010, 4'b1011: begin dec_valid = 1'b1; dec_rd = 1'b1; dec_rmw = 1'b1; end
            4'b1100, 4'b1101: begin dec_valid = 1'b1; dec_rd = 1'b1; dec_gp = 1'b1; end
            4'b0011:          begin dec_valid = 1'b1; end
            4'b0001:          begin dec_valid = 1'b1; dec_byte = 1'b1; end
            4'b0101:          begin dec_valid = 1'b1; dec_gp = 1'b1; end
            default:          begin dec_valid = 1'b0; end
        endcase
    end

`ifdef J11PINS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          in_wait;

    assign in_wait      = (state == S_RWAIT) || (state == S_WWAIT);
    assign wait_expired = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Cycles spent waiting for busack; cleared whenever not waiting.
    always_ff @(posedge clk) begin
        if (rst || !in_wait) wait_cnt <= '0;
        else                 wait_cnt <= wait_cnt + 1'b1;
    end

    // One-cycle timeout pulse, registered on the same edge the FSM gives up.
    always_ff @(posedge clk) begin
        if (rst) bustimeout <= 1'b0;
        else     bustimeout <= in_wait & ~busack & wait_expired;
    end
`else
    assign wait_expired = 1'b0;
    assign bustimeout   = 1'b0;
`endif

    // Bus-cycle sequencer with registered bus and pin outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            dal_out  <= '0;
            dal_oe   <= 1'b0;
            cont_n   <= 1'b1;
            busreq   <= 1'b0;
            buswr    <= 1'b0;
            busgp    <= 1'b0;
            busbyte  <= 1'b0;
            busaddr  <= '0;
            buswdata <= '0;
            cyc_rd   <= 1'b0;
            cyc_rmw  <= 1'b0;
        end else begin
            busreq <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ale_fall && dec_valid) begin
                        busaddr <= dal_in;
                        buswr   <= ~dec_rd;
                        busgp   <= dec_gp;
                        busbyte <= dec_byte;
                        cyc_rd  <= dec_rd;
                        cyc_rmw <= dec_rmw;
                        cont_n  <= 1'b1;
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (sctl_fall) begin
                        busreq <= 1'b1;
                        if (cyc_rd) begin
                            state <= S_RREQ;
                        end else begin
                            buswdata <= dal_in[15:0];
                            state    <= S_WREQ;
                        end
                    end else if (ale_rise) begin
                        cont_n <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_RREQ: state <= S_RWAIT;
                S_RWAIT: begin
                    if (busack) begin
                        dal_out <= busrdata;
                        dal_oe  <= 1'b1;
                        cont_n  <= 1'b0;
                        state   <= S_RDRIVE;
                    end else if (wait_expired) begin
                        dal_out <= 16'o177777;
                        dal_oe  <= 1'b1;
                        cont_n  <= 1'b0;
                        state   <= S_RDRIVE;
                    end
                end
                S_RDRIVE: begin
                    if (sctl_rise) begin
                        dal_oe <= 1'b0;
                        cont_n <= 1'b1;
                        state  <= cyc_rmw ? S_RMWW : S_IDLE;
                    end
                end
                S_RMWW: begin
                    if (sctl_fall) begin
                        buswdata <= dal_in[15:0];
                        buswr    <= 1'b1;
                        busbyte  <= 1'b0;
                        busreq   <= 1'b1;
                        state    <= S_WREQ;
                    end
                end
                S_WREQ: state <= S_WWAIT;
                S_WWAIT: begin
                    if (busack || wait_expired) begin
                        cont_n <= 1'b0;
                        state  <= S_WDONE;
                    end
                end
                S_WDONE: begin
                    if (sctl_rise) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_j11pins.sv
// tb_j11pins: directed bench for j11pins with a transaction-level model.
module tb_j11pins;

    localparam int SYNC = 2;
    localparam int TMO  = 16;
    localparam int TW   = 41;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [21:0] dal_in = '0;
    logic [15:0] dal_out;
    logic        dal_oe;
    logic [3:0]  aio = 4'b1111;
    logic        ale_n = 1'b1;
    logic        sctl_n = 1'b1;
    logic        cont_n;
    logic        busreq, buswr, busgp, busbyte;
    logic [21:0] busaddr;
    logic [15:0] buswdata;
    logic        busack = 1'b0;
    logic [15:0] busrdata = '0;
    logic        bustimeout;

    int n_cmp = 0;
    int n_err = 0;

    logic [TW-1:0] exp_q[$];

    j11pins #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .dal_in(dal_in), .dal_out(dal_out), .dal_oe(dal_oe),
        .aio(aio), .ale_n(ale_n), .sctl_n(sctl_n), .cont_n(cont_n),
        .busreq(busreq), .buswr(buswr), .busgp(busgp), .busbyte(busbyte),
        .busaddr(busaddr), .buswdata(buswdata), .busack(busack),
        .busrdata(busrdata), .bustimeout(bustimeout)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0o required %0o", name, act, exp);
        end
    endtask

    // Model: cycle kinds straight from the AIO code table.
    typedef struct packed {
        logic valid;
        logic rd;
        logic rmw;
        logic gp;
        logic byt;
    } kind_t;

    function automatic kind_t decode(input logic [3:0] code);
        kind_t k = '0;
        if (code inside {4'b1000, 4'b1001}) k = '{1, 1, 0, 0, 0};
        if (code inside {4'b1010, 4'b1011}) k = '{1, 1, 1, 0, 0};
        if (code inside {4'b1100, 4'b1101}) k = '{1, 1, 0, 1, 0};
        if (code == 4'b0011) k = '{1, 0, 0, 0, 0};
        if (code == 4'b0001) k = '{1, 0, 0, 0, 1};
        if (code == 4'b0101) k = '{1, 0, 0, 1, 0};
        return k;
    endfunction

    function automatic logic [TW-1:0] pack(input logic [21:0] a, input logic wr,
                                           input logic gp, input logic byt,
                                           input logic [15:0] wd);
        return {a, wr, gp, byt, wr ? wd : 16'h0};
    endfunction

    // scoreboard: every busreq pulse checked against the expected queue
    logic        pending = 1'b0;
    logic        prev_req = 1'b0;
    logic [24:0] held;

    always @(negedge clk) begin
        if (rst) begin
            pending  = 1'b0;
            prev_req = 1'b0;
        end else begin
`ifndef J11PINS_TIMEOUT_EN
            check("bustimeout_tied", bustimeout, 0);
`else
            if (bustimeout) pending = 1'b0;
`endif
            if (busreq) begin
                check("busreq_back_to_back", prev_req, 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL busreq_unexpected: got addr %0o wr %0b required none", busaddr, buswr);
                end else begin
                    check("busreq_txn", pack(busaddr, buswr, busgp, busbyte, buswdata), exp_q.pop_front());
                end
                pending = 1'b1;
                held    = {busaddr, buswr, busgp, busbyte};
            end else if (pending) begin
                check("req_fields_stable", {busaddr, buswr, busgp, busbyte}, held);
                if (busack) pending = 1'b0;
            end
            prev_req = busreq;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req(output int edges);
        edges = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (busreq) begin
                edges = i;
                break;
            end
        end
        if (edges == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL busreq_wait: got no busreq in 20 cycles required one");
        end
    endtask

    task automatic ack(input logic [15:0] d, input int delay);
        tick(delay);
        busack   = 1'b1;
        busrdata = d;
        tick(1);
        busack   = 1'b0;
        busrdata = 16'($urandom_range(0, 16'hffff));
    endtask

    task automatic bus_cycle(input logic [3:0] code, input logic [21:0] addr,
                             input logic [15:0] wdata, input logic [15:0] rdata,
                             input logic [15:0] wdata2, input int delay);
        kind_t k;
        int    e;
        k = decode(code);
        if (k.rd) exp_q.push_back(pack(addr, 1'b0, k.gp, 1'b0, 16'h0));
        else      exp_q.push_back(pack(addr, 1'b1, k.gp, k.byt, wdata));
        if (k.rmw) exp_q.push_back(pack(addr, 1'b1, 1'b0, 1'b0, wdata2));

        dal_in = addr;
        aio    = code;
        ale_n  = 1'b0;
        tick(SYNC + 2);
        check("cont_n_after_ale", cont_n, 1);

        dal_in = k.rd ? 22'h3fffff : {6'b0, wdata};
        sctl_n = 1'b0;
        wait_req(e);
        check("sctl_to_busreq_latency", e, SYNC + 1);
        ack(rdata, delay);
        check("cont_n_after_ack", cont_n, 0);
        if (k.rd) begin
            check("dal_oe_after_ack", dal_oe, 1);
            check("dal_out_after_ack", dal_out, rdata);
        end
        sctl_n = 1'b1;
        tick(SYNC + 2);
        if (k.rd) begin
            check("dal_oe_after_sctl_rise", dal_oe, 0);
            check("cont_n_after_read", cont_n, 1);
        end else begin
            check("cont_n_after_write", cont_n, 0);
        end

        if (k.rmw) begin
            dal_in = {6'b0, wdata2};
            sctl_n = 1'b0;
            wait_req(e);
            check("rmw_write_latency", e, SYNC + 1);
            ack(16'h0, delay);
            check("rmw_cont_n_after_ack", cont_n, 0);
            check("rmw_dal_oe_write", dal_oe, 0);
            sctl_n = 1'b1;
            tick(SYNC + 2);
            check("rmw_cont_n_done", cont_n, 0);
        end

        ale_n = 1'b1;
        aio   = 4'b1111;
        tick(SYNC + 2);
        check("exp_q_drained", exp_q.size(), 0);
    endtask

    // stimulus
    initial begin
        int e;
        rst = 1'b1;
        tick(3);
        check("reset_outputs",
              {dal_oe, dal_out, cont_n, busreq, buswr, busgp, busbyte, busaddr, buswdata, bustimeout},
              {1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 16'h0, 1'b0});
        rst = 1'b0;
        tick(2);

        // model pins: hand-derived decode results
        check("model_decode_gp_read", decode(4'b1101), 5'b11010);
        check("model_decode_other", decode(4'b0111), 5'b00000);

        // word read
        bus_cycle(4'b1001, 22'o17772300, 16'h0, 16'o123456, 16'h0, 5);
        check("word_read_addr", busaddr, 22'o17772300);
        check("word_read_wr", buswr, 0);
        check("word_read_data", dal_out, 16'o123456);

        // byte write
        bus_cycle(4'b0001, 22'o1001, 16'o000377, 16'h0, 16'h0, 2);
        check("byte_write_data", buswdata, 16'o000377);
        check("byte_write_flags", {buswr, busbyte, busgp}, 3'b110);

        // idle and unlisted codes: no transfer, cont_n untouched
        for (int i = 0; i < 2; i++) begin
            aio    = (i == 0) ? 4'b1111 : 4'b0111;
            dal_in = 22'o7654321;
            ale_n  = 1'b0;
            tick(SYNC + 3);
            ale_n  = 1'b1;
            tick(SYNC + 3);
            check("idle_code_cont_n", cont_n, 0);
            check("idle_code_addr", busaddr, 22'o1001);
        end

        // read-modify-write
        bus_cycle(4'b1011, 22'o2000, 16'h0, 16'o5, 16'o6, 3);
        check("rmw_final_addr", busaddr, 22'o2000);
        check("rmw_final_wr_data", {buswr, buswdata}, {1'b1, 16'o6});

        // GP write
        bus_cycle(4'b0101, 22'o17777700, 16'o052525, 16'h0, 16'h0, 1);
        check("gp_write_gp", busgp, 1);

        // ALE pulse without SCTL: back to idle and release the CPU
        aio    = 4'b1000;
        dal_in = 22'o3000;
        ale_n  = 1'b0;
        tick(SYNC + 2);
        check("ale_only_cont_n_hold", cont_n, 1);
        ale_n = 1'b1;
        tick(SYNC + 2);
        check("ale_only_cont_n_release", cont_n, 0);

        // GP read, then a stray busack while idle
        bus_cycle(4'b1101, 22'o0, 16'h0, 16'o000314, 16'h0, 4);
        check("gp_read_flags", {busgp, buswr}, 2'b10);
        busack   = 1'b1;
        busrdata = 16'o7777;
        tick(1);
        busack = 1'b0;
        tick(2);
        check("stray_ack_outputs", {dal_oe, cont_n, dal_out}, {1'b0, 1'b1, 16'o000314});

        // reset during RWAIT, then a late busack
        exp_q.push_back(pack(22'o17777560, 1'b0, 1'b0, 1'b0, 16'h0));
        aio    = 4'b1000;
        dal_in = 22'o17777560;
        ale_n  = 1'b0;
        tick(SYNC + 2);
        sctl_n = 1'b0;
        wait_req(e);
        tick(2);
        rst    = 1'b1;
        ale_n  = 1'b1;
        sctl_n = 1'b1;
        aio    = 4'b1111;
        tick(1);
        check("reset_mid_cycle",
              {dal_oe, dal_out, cont_n, busreq, buswr, busgp, busbyte, busaddr, buswdata, bustimeout},
              {1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 16'h0, 1'b0});
        tick(1);
        rst      = 1'b0;
        busack   = 1'b1;
        busrdata = 16'o55555;
        tick(1);
        busack = 1'b0;
        tick(3);
        check("late_ack_ignored", {dal_oe, cont_n, dal_out}, {1'b0, 1'b1, 16'h0});
        bus_cycle(4'b1000, 22'o1234, 16'h0, 16'o4321, 16'h0, 1);

`ifdef J11PINS_TIMEOUT_EN
        // no busack: timeout completes the read with all-ones data
        exp_q.push_back(pack(22'o4444, 1'b0, 1'b0, 1'b0, 16'h0));
        aio    = 4'b1001;
        dal_in = 22'o4444;
        ale_n  = 1'b0;
        tick(SYNC + 2);
        sctl_n = 1'b0;
        wait_req(e);
        e = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (bustimeout) begin
                e = i;
                break;
            end
        end
        check("timeout_edges", e, TMO + 1);
        check("timeout_read_result", {dal_oe, cont_n, dal_out}, {1'b1, 1'b0, 16'o177777});
        tick(1);
        check("timeout_single_pulse", bustimeout, 0);
        busack = 1'b1;
        tick(1);
        busack = 1'b0;
        check("timeout_late_ack", dal_out, 16'o177777);
        sctl_n = 1'b1;
        tick(SYNC + 2);
        check("timeout_release", {dal_oe, cont_n}, 2'b01);
        ale_n = 1'b1;
        aio   = 4'b1111;
        tick(SYNC + 2);
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/j11pins.md
Name: j11pins

Overview:
- Pin-level front end for the DCJ11 CPU, directly upstream of the J11 bus request stage.
- Synchronises the J11 strobes (ALE_n, SCTL_n) and latches the multiplexed DAL address and AIO code.
- Turns each J11 bus cycle into exactly one single-cycle busreq transaction, or two for read-modify-write.
- Holds the CPU with CONT_n until busack returns, and drives read data back onto DAL.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on ale_n/sctl_n before edge detection (min 2).
- TIMEOUT_CYCLES, 255: busack wait limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dal_in  in  22  DAL pins, input path
- dal_out  out  16  read data to DAL pins
- dal_oe  out  1  DAL[15:0] output enable
- aio  in  4  J11 AIO cycle code
- ale_n  in  1  address latch enable, active low
- sctl_n  in  1  strobe control, active low
- cont_n  out  1  continue; low = proceed, high = stall CPU
- busreq  out  1  single-cycle transaction request
- buswr  out  1  1 = write
- busgp  out  1  general-purpose/IACK cycle
- busbyte  out  1  byte write (busaddr[0] selects the lane)
- busaddr  out  22  latched address
- buswdata  out  16  write data
- busack  in  1  transaction done, single cycle
- busrdata  in  16  read data, valid with busack
- bustimeout  out  1  timeout pulse; tied 0 without the macro

Behaviour:
- Reset values: dal_oe=0, dal_out=0, cont_n=1, busreq=0, buswr=0, busgp=0, busbyte=0, busaddr=0, buswdata=0, bustimeout=0. State goes to IDLE.
- Reset mid-operation: abort the cycle. A busack arriving after reset is ignored.
- ale_n and sctl_n pass through SYNC_STAGES flops. Edges are detected on the synchronised values.
- dal_in and aio are sampled in the cycle the synchronised edge is seen. The pins are stable by then.
- AIO decode:
  - 1111: idle (no transfer).
  - 1000, 1001: read.
  - 1010, 1011: read-modify-write (RMW).
  - 1100: IACK read, busgp=1.
  - 1101: GP read, busgp=1.
  - 0011: word write.
  - 0001: byte write, busbyte=1.
  - 0101: GP write, busgp=1.
  - Any other code: treated as idle.
- IDLE: on an ALE fall with a non-idle code, latch busaddr=dal_in[21:0] and the decoded type, set cont_n=1, go to ADDR. ALE falls in any other state are ignored.
- ADDR: on an SCTL fall, go to RREQ for a read, or go to WREQ and latch buswdata=dal_in[15:0] for a write. On an ALE rise with no SCTL fall, return to IDLE and set cont_n=0.
- RREQ: busreq=1 for exactly one cycle with buswr=0, then go to RWAIT.
- RWAIT: on busack, set dal_out=busrdata, dal_oe=1 and cont_n=0 in the next cycle, then go to RDRIVE.
- RDRIVE: on an SCTL rise, set dal_oe=0 and cont_n=1. RMW goes to RMWW; everything else goes to IDLE.
- RMWW: on an SCTL fall, latch buswdata and go to WREQ (buswr=1, same busaddr, busbyte=0).
- WREQ: busreq=1 for one cycle with buswr=1, then go to WWAIT.
- WWAIT: on busack, set cont_n=0 and go to WDONE.
- WDONE: on an SCTL rise, go to IDLE. cont_n stays 0 until the next ALE fall.
- busack in any state other than RWAIT/WWAIT is ignored.
- busreq is never high on two consecutive cycles.
- Latency: SCTL fall seen → busreq one cycle later. busack → cont_n=0 one cycle later.
- busaddr, buswr, busgp and busbyte stay stable from busreq until busack.

Optional Feature:
- Macro: J11PINS_TIMEOUT_EN.
- With the macro: a counter runs in RWAIT/WWAIT. If it reaches TIMEOUT_CYCLES with no busack:
  - bustimeout pulses for 1 cycle.
  - Reads return dal_out=16'o177777.
  - The cycle then completes as if acked.
  - A late busack is ignored.
- Without the macro: the block waits indefinitely and bustimeout is tied 0.

Test Plan:
- Word read: aio=1001, DAL=22'o17772300, SCTL fall; busack with 16'o123456 after 5 cycles → one busreq with buswr=0, busaddr=22'o17772300; dal_out=16'o123456, dal_oe=1, cont_n=0 one cycle after busack.
- Byte write: aio=0001, addr=22'o1001, data=16'o000377 → busreq with buswr=1, busbyte=1, buswdata=16'o000377; cont_n=0 the cycle after busack.
- RMW: aio=1011, addr=22'o2000, read ack 16'o5, second SCTL with data 16'o6 → exactly two busreq pulses, read then write, both at 22'o2000.
- GP read: aio=1101, DAL[7:0]=8'o0 → busgp=1, buswr=0, data returned on DAL; a stray busack in IDLE produces no change.
- rst asserted during RWAIT, followed by a late busack → all outputs at reset values, no dal_oe; the next cycle proceeds normally.
- With J11PINS_TIMEOUT_EN and TIMEOUT_CYCLES=16, no busack → bustimeout pulse after 16 cycles, dal_out=16'o177777, cont_n=0.
